// File: rtl/sample_fifo_pkg.sv
// sample_fifo_pkg: shared constants, pointer-width helper and parameter check
// for the sample replay FIFO.
`define SFIFO_PARAM_CHECK(lat, af, ae, depth) \
    if ((lat) < RD_LAT_MIN || (lat) > RD_LAT_MAX || (af) < 1 || (af) > (depth) || (ae) < 0 || (ae) >= (depth)) begin : g_param_err \
        $error("sample_replay_fifo: illegal RD_LAT or threshold parameter"); \
    end

package sample_fifo_pkg;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic int ptr_w(input int depth_bit);
        return depth_bit + 1;
    endfunction
endpackage

// File: rtl/sample_replay_fifo_sdp_ram.sv
// sdp_ram: simple dual-port memory, synchronous write, synchronous read with
// RD_LAT-1 extra output stages; each stage loads only when its enable is set.
module sdp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [RD_LAT-1:0] en,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] pipe [RD_LAT];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // Stages hold when not enabled so the last stage keeps the last delivered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            if (en[0]) pipe[0] <= mem[raddr];
            for (int i = 1; i < RD_LAT; i++)
                if (en[i]) pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[RD_LAT-1];
endmodule

// File: rtl/sample_replay_fifo.sv
// sample_replay_fifo: sample FIFO with a protected replay region (mark/rewind/release),
// occupancy flags, sticky error flags and cancellable read pipeline.
module sample_replay_fifo
    import sample_fifo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH_BIT = 4,
    parameter int RD_LAT    = 2,
    parameter int AF_THRESH = (1 << DEPTH_BIT) - 2,
    parameter int AE_THRESH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_mark,
    input  logic               i_release,
    input  logic               i_rewind,
    input  logic               i_push,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_pop,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_vld,
    output logic               o_full,
    output logic               o_almost_full,
    output logic               o_empty,
    output logic               o_almost_empty,
    output logic [DEPTH_BIT:0] o_count,
    output logic [DEPTH_BIT:0] o_replay_count,
    output logic               o_ovf,
    output logic               o_udf
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam int PW    = ptr_w(DEPTH_BIT);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

    `SFIFO_PARAM_CHECK(RD_LAT, AF_THRESH, AE_THRESH, DEPTH)

    logic [PW-1:0]     rptr, wptr, mark_ptr, base, used;
    logic              mark_vld, ovf, udf;
    logic              rewind, kill, push_acc, pop_acc;
    logic [RD_LAT-1:0] vld_sr, vld_nxt;

    // The write side is bounded by the mark while it is held, protecting the replay region.
    always_comb begin
        base     = mark_vld ? mark_ptr : rptr;
        used     = wptr - base;
        rewind   = i_rewind & mark_vld & ~i_flush;
        kill     = i_flush | rewind;
        push_acc = i_push & ~o_full & ~i_flush;
        pop_acc  = i_pop & ~o_empty & ~kill;
        vld_nxt  = kill ? '0 : RD_LAT'({vld_sr, pop_acc});
    end

    assign o_count        = wptr - rptr;
    assign o_replay_count = mark_vld ? wptr - mark_ptr : '0;
    assign o_full         = used == DEPTH_P;
    assign o_almost_full  = used >= AF_P;
    assign o_empty        = o_count == '0;
    assign o_almost_empty = o_count <= AE_P;
    assign o_ovf          = ovf;
    assign o_udf          = udf;
    assign o_vld          = vld_sr[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr     <= '0;
            wptr     <= '0;
            mark_ptr <= '0;
            mark_vld <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            vld_sr   <= '0;
        end else if (i_flush) begin
            rptr     <= '0;
            wptr     <= '0;
            mark_ptr <= '0;
            mark_vld <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            vld_sr   <= '0;
        end else begin
            wptr <= wptr + PW'(push_acc);
            rptr <= rewind ? mark_ptr : rptr + PW'(pop_acc);
            // Mark captures rptr before a same-cycle pop advances it.
            if (!rewind && i_mark) begin
                mark_ptr <= rptr;
                mark_vld <= 1'b1;
            end else if (!rewind && i_release) begin
                mark_vld <= 1'b0;
            end
            ovf    <= ovf | (i_push & o_full);
            udf    <= udf | (i_pop & o_empty);
            vld_sr <= vld_nxt;
        end
    end

    sdp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(DEPTH_BIT),
        .RD_LAT(RD_LAT)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (push_acc),
        .waddr(wptr[DEPTH_BIT-1:0]),
        .wdata(i_data),
        .raddr(rptr[DEPTH_BIT-1:0]),
        .en   (vld_nxt),
        .rdata(o_data)
    );
endmodule

// File: tb/tb_sample_replay_fifo.sv
// tb_sample_replay_fifo: directed table, corner sequences and random traffic
// against a queue-based reference model of the replay FIFO.
module tb_sample_replay_fifo;
    localparam int DW = 16, DB = 2, LAT = 2, D = 1 << DB, AF = D - 2, AE = 1;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          i_flush = 1'b0, i_mark = 1'b0, i_release = 1'b0, i_rewind = 1'b0;
    logic          i_push = 1'b0, i_pop = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [DW-1:0] o_data;
    logic          o_vld, o_full, o_almost_full, o_empty, o_almost_empty, o_ovf, o_udf;
    logic [DB:0]   o_count, o_replay_count;

    always #5 clk = ~clk;

    sample_replay_fifo #(.DATA_W(DW), .DEPTH_BIT(DB), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_mark(i_mark), .i_release(i_release),
        .i_rewind(i_rewind), .i_push(i_push), .i_data(i_data), .i_pop(i_pop),
        .o_data(o_data), .o_vld(o_vld), .o_full(o_full), .o_almost_full(o_almost_full),
        .o_empty(o_empty), .o_almost_empty(o_almost_empty), .o_count(o_count),
        .o_replay_count(o_replay_count), .o_ovf(o_ovf), .o_udf(o_udf)
    );

    // Reference model: absolute indices into the history of pushed words since the last flush.
    typedef struct { int due; logic [DW-1:0] d; } pend_t;
    logic [DW-1:0] hist[$];
    pend_t         pend[$];
    int            rd, wr, mk, edge_n, nvec, nerr;
    bit            mv, ovf, udf, exp_vld;
    logic [DW-1:0] last_d;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete(); pend.delete();
        rd = 0; wr = 0; mk = 0; mv = 0; ovf = 0; udf = 0; exp_vld = 0; last_d = '0;
    endtask

    task automatic model_edge(input logic fl, mk_i, rl, rw_i, pu, input logic [DW-1:0] d, input logic po);
        int    bs;
        bit    full, empty, rw, push_ok, pop_ok;
        pend_t p;
        bs = mv ? mk : rd;
        full = (wr - bs) == D;
        empty = wr == rd;
        edge_n++;
        exp_vld = 0;
        if (fl) begin
            hist.delete(); pend.delete();
            rd = 0; wr = 0; mk = 0; mv = 0; ovf = 0; udf = 0;
        end else begin
            rw = rw_i && mv;
            push_ok = pu && !full;
            pop_ok = po && !empty && !rw;
            if (pu && full) ovf = 1;
            if (po && empty) udf = 1;
            if (rw) pend.delete();
            if (pop_ok) begin
                p.due = edge_n + LAT - 1;
                p.d = hist[rd];
                pend.push_back(p);
            end
            if (!rw && mk_i) begin mk = rd; mv = 1; end
            else if (!rw && rl) mv = 0;
            rd = rw ? mk : rd + int'(pop_ok);
            if (push_ok) begin hist.push_back(d); wr++; end
        end
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            exp_vld = 1;
            last_d = pend[0].d;
            void'(pend.pop_front());
        end
    endtask

    task automatic check_all();
        int used, cnt;
        used = wr - (mv ? mk : rd);
        cnt = wr - rd;
        chk("o_vld", o_vld, exp_vld);
        chk("o_data", o_data, last_d);
        chk("o_full", o_full, used == D);
        chk("o_almost_full", o_almost_full, (D - used) <= (D - AF));
        chk("o_empty", o_empty, cnt == 0);
        chk("o_almost_empty", o_almost_empty, cnt <= AE);
        chk("o_count", o_count, cnt);
        chk("o_replay_count", o_replay_count, mv ? wr - mk : 0);
        chk("o_ovf", o_ovf, ovf);
        chk("o_udf", o_udf, udf);
    endtask

    task automatic step(input logic fl, mk_i, rl, rw_i, pu, input logic [DW-1:0] d, input logic po);
        @(negedge clk);
        i_flush = fl; i_mark = mk_i; i_release = rl; i_rewind = rw_i;
        i_push = pu; i_data = d; i_pop = po;
        model_edge(fl, mk_i, rl, rw_i, pu, d, po);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();  step(0, 0, 0, 0, 0, '0, 0); endtask
    task automatic flush(); step(1, 0, 0, 0, 0, '0, 0); endtask
    task automatic push(input logic [DW-1:0] d); step(0, 0, 0, 0, 1, d, 0); endtask
    task automatic pop();   step(0, 0, 0, 0, 0, '0, 1); endtask

    typedef struct {
        logic fl, mk, rl, rw, pu; logic [DW-1:0] d; logic po;
        logic vld; logic [DW-1:0] dat; logic full, empty; logic [DB:0] cnt, rep; logic ovf;
    } vec_t;
    vec_t tbl[25];

    initial begin
        // fl mk rl rw pu data po | vld data full empty cnt rep ovf
        tbl[0]  = '{0,0,0,0,1,16'hA1,0, 0,16'h00,0,0,3'd1,3'd0,0};
        tbl[1]  = '{0,0,0,0,1,16'hA2,0, 0,16'h00,0,0,3'd2,3'd0,0};
        tbl[2]  = '{0,0,0,0,1,16'hA3,0, 0,16'h00,0,0,3'd3,3'd0,0};
        tbl[3]  = '{0,0,0,0,1,16'hA4,0, 0,16'h00,1,0,3'd4,3'd0,0};
        tbl[4]  = '{0,0,0,0,1,16'hA5,0, 0,16'h00,1,0,3'd4,3'd0,1};
        tbl[5]  = '{0,0,0,0,0,16'h00,1, 0,16'h00,0,0,3'd3,3'd0,1};
        tbl[6]  = '{0,0,0,0,0,16'h00,1, 1,16'hA1,0,0,3'd2,3'd0,1};
        tbl[7]  = '{0,0,0,0,0,16'h00,1, 1,16'hA2,0,0,3'd1,3'd0,1};
        tbl[8]  = '{0,0,0,0,0,16'h00,1, 1,16'hA3,0,1,3'd0,3'd0,1};
        tbl[9]  = '{0,0,0,0,0,16'h00,0, 1,16'hA4,0,1,3'd0,3'd0,1};
        tbl[10] = '{0,0,0,0,0,16'h00,0, 0,16'hA4,0,1,3'd0,3'd0,1};
        tbl[11] = '{0,0,0,0,1,16'hA1,0, 0,16'hA4,0,0,3'd1,3'd0,1};
        tbl[12] = '{0,0,0,0,1,16'hA2,0, 0,16'hA4,0,0,3'd2,3'd0,1};
        tbl[13] = '{0,0,0,0,1,16'hA3,0, 0,16'hA4,0,0,3'd3,3'd0,1};
        tbl[14] = '{0,1,0,0,0,16'h00,0, 0,16'hA4,0,0,3'd3,3'd3,1};
        tbl[15] = '{0,0,0,0,0,16'h00,1, 0,16'hA4,0,0,3'd2,3'd3,1};
        tbl[16] = '{0,0,0,0,0,16'h00,1, 1,16'hA1,0,0,3'd1,3'd3,1};
        tbl[17] = '{0,0,0,0,0,16'h00,1, 1,16'hA2,0,1,3'd0,3'd3,1};
        tbl[18] = '{0,0,0,0,0,16'h00,0, 1,16'hA3,0,1,3'd0,3'd3,1};
        tbl[19] = '{0,0,0,1,0,16'h00,0, 0,16'hA3,0,0,3'd3,3'd3,1};
        tbl[20] = '{0,0,0,0,0,16'h00,1, 0,16'hA3,0,0,3'd2,3'd3,1};
        tbl[21] = '{0,0,0,0,0,16'h00,1, 1,16'hA1,0,0,3'd1,3'd3,1};
        tbl[22] = '{0,0,0,0,0,16'h00,1, 1,16'hA2,0,1,3'd0,3'd3,1};
        tbl[23] = '{0,0,0,0,0,16'h00,0, 1,16'hA3,0,1,3'd0,3'd3,1};
        tbl[24] = '{0,0,0,0,0,16'h00,0, 0,16'hA3,0,1,3'd0,3'd3,1};

        nvec = 0; nerr = 0; edge_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Fill/overflow/drain, then mark-and-replay.
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].fl, tbl[i].mk, tbl[i].rl, tbl[i].rw, tbl[i].pu, tbl[i].d, tbl[i].po);
            chk($sformatf("row%0d_vld", i), o_vld, tbl[i].vld);
            chk($sformatf("row%0d_data", i), o_data, tbl[i].dat);
            chk($sformatf("row%0d_full", i), o_full, tbl[i].full);
            chk($sformatf("row%0d_empty", i), o_empty, tbl[i].empty);
            chk($sformatf("row%0d_count", i), o_count, tbl[i].cnt);
            chk($sformatf("row%0d_replay", i), o_replay_count, tbl[i].rep);
            chk($sformatf("row%0d_ovf", i), o_ovf, tbl[i].ovf);
        end

        // Protection: mark holds space even after pops.
        flush();
        step(0, 1, 0, 0, 0, '0, 0);
        push(16'hC1); push(16'hC2); pop(); pop();
        push(16'hC3); push(16'hC4);
        chk("t3_full_marked", o_full, 1'b1);
        chk("t3_count_marked", o_count, 3'd2);
        push(16'hC5);
        chk("t3_ovf", o_ovf, 1'b1);
        step(0, 0, 1, 0, 0, '0, 0);
        chk("t3_full_released", o_full, 1'b0);

        // Rewind one cycle after a pop cancels that pop's delivery.
        flush();
        push(16'hB1); push(16'hB2);
        step(0, 1, 0, 0, 0, '0, 0);
        pop();
        step(0, 0, 0, 1, 0, '0, 0);
        chk("t4_vld_killed", o_vld, 1'b0);
        pop();
        idle();
        chk("t4_vld_replay", o_vld, 1'b1);
        chk("t4_data_replay", o_data, 16'hB1);

        // Flush during a push/pop burst.
        flush();
        pop();
        for (int i = 0; i < 5; i++) push(16'hE0 + 16'(i));
        pop();
        step(0, 0, 0, 0, 1, 16'hE8, 1);
        step(1, 0, 0, 0, 1, 16'hE9, 1);
        chk("t5_empty", o_empty, 1'b1);
        chk("t5_count", o_count, 3'd0);
        chk("t5_ovf", o_ovf, 1'b0);
        chk("t5_udf", o_udf, 1'b0);
        chk("t5_vld", o_vld, 1'b0);
        idle();
        chk("t5_vld_after", o_vld, 1'b0);
        chk("t5_count_after", o_count, 3'd0);

        // Asynchronous reset with a read in flight.
        for (int i = 0; i < 5; i++) push(16'h5A0 + 16'(i));
        pop(); pop();
        chk("t6_vld_before", o_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_vld_reset", o_vld, 1'b0);
        chk("t6_data_reset", o_data, 16'h0);
        @(negedge clk) rst_n = 1'b1;
        pop();
        chk("t6_udf", o_udf, 1'b1);
        idle();
        chk("t6_no_vld", o_vld, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, 16'($urandom),
                 $urandom_range(0, 1) == 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
